// File: rtl/mul_seq_param.sv
// rtl/mul_seq_param.sv - parametrised radix-2 shift-add multiplier with start/rdy/vld handshake; optional signed mode via MUL_SIGNED_EN
module mul_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
`ifdef MUL_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 rdy,
    output logic                 vld,
    output logic [2*WIDTH-1:0]   res
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   res_q;
    logic [CW-1:0]        step_q;
    logic                 neg_q;
    logic                 rdy_q;
    logic                 vld_q;

    logic [WIDTH-1:0]     mag1_d;
    logic [WIDTH-1:0]     mag2_d;
    logic                 neg_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   res_d;

    // Operand conditioning at capture: signed operands become magnitudes plus a result-sign flag.
    // The most negative value negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        mag1_d = op1;
        mag2_d = op2;
        neg_d  = 1'b0;
`ifdef MUL_SIGNED_EN
        if (sgn) begin
            if (op1[WIDTH-1]) mag1_d = -op1;
            if (op2[WIDTH-1]) mag2_d = -op2;
            neg_d = op1[WIDTH-1] ^ op2[WIDTH-1];
        end
`endif
    end

    // One radix-2 step: add the shifted multiplicand when the current multiplier bit is set;
    // the final product is negated only when the operand signs differed.
    always_comb begin
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        res_d = neg_q ? -acc_q : acc_q;
    end

    // Control FSM: WIDTH step cycles, then one cycle that publishes the product and raises vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            step_q   <= '0;
            neg_q    <= 1'b0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag1_d};
                        mplier_q <= mag2_d;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        step_q   <= '0;
                        rdy_q    <= 1'b0;
                        vld_q    <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (step_q == CW'(WIDTH)) begin
                        res_q   <= res_d;
                        rdy_q   <= 1'b1;
                        vld_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        step_q   <= step_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdy = rdy_q;
    assign vld = vld_q;
    assign res = res_q;

endmodule
